// File: rtl/macro_sched_pkg.sv
// Shared widths and enums for the macro command scheduler.
package macro_sched_pkg;
  localparam int CMP_CMD_W  = 25;
  localparam int LDST_CMD_W = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CMP_ISSUE = 2'd1,
    CMP_GUARD = 2'd2,
    LDST_HOLD = 2'd3
  } sched_state_t;

  typedef enum logic {
    CMP  = 1'b0,
    LDST = 1'b1
  } grant_t;
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered storage; head is visible the cycle after push.
module cmd_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW:0]             wr_ptr_q, rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/macro_cmd_scheduler.sv
// Arbitrates the single CIM macro between buffered compute commands and
// unbackpressured load/store pulses, round-robin, never overlapping the two.
module macro_cmd_scheduler
  import macro_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int LDST_CYCLES = 2,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cq_valid,
  output logic                  cq_ready,
  input  logic [CMP_CMD_W-1:0]  cq_command,
  input  logic                  ls_valid,
  output logic                  ls_ready,
  input  logic [LDST_CMD_W-1:0] ls_command,
  output logic                  Compute_valid,
  input  logic                  Compute_ready,
  output logic [CMP_CMD_W-1:0]  Compute_command,
  output logic                  ExLdSt_valid,
  output logic [LDST_CMD_W-1:0] ExLdSt_command,
  output logic                  busy,
  output logic [LW-1:0]         fifo_level
);
  sched_state_t          state_q, state_d;
  grant_t                last_q, last_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic [CMP_CMD_W-1:0]  cmp_cmd_q, cmp_cmd_d;
  logic                  ls_vld_q, ls_vld_d;
  logic [LDST_CMD_W-1:0] ls_cmd_q, ls_cmd_d;
  logic                  push, pop, full, empty, cmp_elig, ls_elig;
  logic [CMP_CMD_W-1:0]  head;

  assign cq_ready = !full;
  assign push     = cq_valid && !full;

  cmd_fifo #(.W(CMP_CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cq_command),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Both classes need an idle macro; load/store cannot be stalled once issued.
  assign cmp_elig = !empty && Compute_ready;
  assign ls_elig  = ls_valid && Compute_ready;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    cmp_vld_d = cmp_vld_q;
    cmp_cmd_d = cmp_cmd_q;
    ls_vld_d  = 1'b0;
    ls_cmd_d  = ls_cmd_q;
    ls_ready  = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmp_elig && (!ls_elig || last_q == LDST)) begin
          cmp_cmd_d = head;
          cmp_vld_d = 1'b1;
          last_d    = CMP;
          state_d   = CMP_ISSUE;
        end else if (ls_elig) begin
          ls_ready  = 1'b1;
          ls_cmd_d  = ls_command;
          ls_vld_d  = 1'b1;
          cnt_d     = 4'(LDST_CYCLES);
          last_d    = LDST;
          state_d   = LDST_HOLD;
        end
      end
      CMP_ISSUE: begin
        if (Compute_ready) begin
          pop       = 1'b1;
          cmp_vld_d = 1'b0;
          state_d   = CMP_GUARD;
        end
      end
      CMP_GUARD: state_d = IDLE;
      LDST_HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= LDST;
      cnt_q     <= '0;
      cmp_vld_q <= 1'b0;
      cmp_cmd_q <= '0;
      ls_vld_q  <= 1'b0;
      ls_cmd_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_cmd_q <= cmp_cmd_d;
      ls_vld_q  <= ls_vld_d;
      ls_cmd_q  <= ls_cmd_d;
    end
  end

  assign Compute_valid   = cmp_vld_q;
  assign Compute_command = cmp_cmd_q;
  assign ExLdSt_valid    = ls_vld_q;
  assign ExLdSt_command  = ls_cmd_q;
  assign busy            = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_macro_cmd_scheduler.sv
// Directed bench for macro_cmd_scheduler (FIFO_DEPTH 4, LDST_CYCLES 3).
module tb_macro_cmd_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        cq_valid, cq_ready;
  logic [24:0] cq_command;
  logic        ls_valid, ls_ready;
  logic [6:0]  ls_command;
  logic        Compute_valid, Compute_ready;
  logic [24:0] Compute_command;
  logic        ExLdSt_valid;
  logic [6:0]  ExLdSt_command;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  macro_cmd_scheduler #(.FIFO_DEPTH(4), .LDST_CYCLES(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .cq_valid        (cq_valid),
    .cq_ready        (cq_ready),
    .cq_command      (cq_command),
    .ls_valid        (ls_valid),
    .ls_ready        (ls_ready),
    .ls_command      (ls_command),
    .Compute_valid   (Compute_valid),
    .Compute_ready   (Compute_ready),
    .Compute_command (Compute_command),
    .ExLdSt_valid    (ExLdSt_valid),
    .ExLdSt_command  (ExLdSt_command),
    .busy            (busy),
    .fifo_level      (fifo_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    cq_valid = 0; cq_command = '0; ls_valid = 0; ls_command = '0; Compute_ready = 1;
    rst = 1'b1;
    tick();
    do_reset();
    // reset state
    chk("rst_cvalid", 32'(Compute_valid), 0);
    chk("rst_ccmd",   32'(Compute_command), 0);
    chk("rst_lsvalid",32'(ExLdSt_valid), 0);
    chk("rst_lscmd",  32'(ExLdSt_command), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_level",  32'(fifo_level), 0);
    chk("rst_cqrdy",  32'(cq_ready), 1);

    // three compute commands, ready held high
    cq_valid = 1; cq_command = 25'h1;
    tick();
    chk("t1_lvl_b", 32'(fifo_level), 1);
    chk("t1_cv_b",  32'(Compute_valid), 0);
    chk("t1_busy_b",32'(busy), 1);
    cq_command = 25'h2;
    tick();
    chk("t1_cv_c",  32'(Compute_valid), 1);
    chk("t1_cmd_c", 32'(Compute_command), 'h1);
    chk("t1_lvl_c", 32'(fifo_level), 2);
    cq_command = 25'h3;
    tick();
    chk("t1_cv_d",  32'(Compute_valid), 0);
    chk("t1_lvl_d", 32'(fifo_level), 2);
    cq_valid = 0;
    tick();
    chk("t1_cv_e",  32'(Compute_valid), 0);
    tick();
    chk("t1_cv_f",  32'(Compute_valid), 1);
    chk("t1_cmd_f", 32'(Compute_command), 'h2);
    tick();
    chk("t1_cv_g",  32'(Compute_valid), 0);
    chk("t1_lvl_g", 32'(fifo_level), 1);
    tick();
    chk("t1_cv_h",  32'(Compute_valid), 0);
    tick();
    chk("t1_cv_i",  32'(Compute_valid), 1);
    chk("t1_cmd_i", 32'(Compute_command), 'h3);
    tick();
    chk("t1_lvl_j", 32'(fifo_level), 0);
    chk("t1_busy_j",32'(busy), 1);
    tick();
    chk("t1_busy_k",32'(busy), 0);

    // compute vs load/store tie after reset, then alternation
    do_reset();
    cq_valid = 1; cq_command = 25'h0AAAAAA;
    tick();
    ls_valid = 1; ls_command = 7'h25; cq_command = 25'h0BBBBBB;
    #1;
    chk("t2_lsrdy_tie1", 32'(ls_ready), 0);
    tick();
    cq_valid = 0;
    #1;
    chk("t2_cv_first",  32'(Compute_valid), 1);
    chk("t2_cmd_first", 32'(Compute_command), 'h0AAAAAA);
    chk("t2_lsrdy_iss", 32'(ls_ready), 0);
    tick();
    chk("t2_lsrdy_grd", 32'(ls_ready), 0);
    tick();
    chk("t2_lsrdy_gnt", 32'(ls_ready), 1);
    tick();
    ls_valid = 0;
    chk("t2_exv_w",   32'(ExLdSt_valid), 1);
    chk("t2_excmd_w", 32'(ExLdSt_command), 'h25);
    chk("t2_cv_w",    32'(Compute_valid), 0);
    tick();
    chk("t2_exv_x",   32'(ExLdSt_valid), 0);
    chk("t2_cv_x",    32'(Compute_valid), 0);
    tick();
    chk("t2_cv_y",    32'(Compute_valid), 0);
    tick();
    chk("t2_cv_z",    32'(Compute_valid), 0);
    cq_valid = 1; cq_command = 25'h0CCCCCC; ls_valid = 1; ls_command = 7'h11;
    tick();
    cq_valid = 0;
    chk("t2_cv_aa",   32'(Compute_valid), 1);
    chk("t2_cmd_aa",  32'(Compute_command), 'h0BBBBBB);
    tick();
    chk("t2_lsrdy_bb",32'(ls_ready), 0);
    tick();
    chk("t2_lsrdy_cc",32'(ls_ready), 1);
    tick();
    ls_valid = 0;
    chk("t2_exv_dd",  32'(ExLdSt_valid), 1);
    chk("t2_excmd_dd",32'(ExLdSt_command), 'h11);
    chk("t2_cv_dd",   32'(Compute_valid), 0);
    chk("t2_lvl_dd",  32'(fifo_level), 1);

    // FIFO fills with macro not ready; then stall in CMP_ISSUE
    do_reset();
    Compute_ready = 0;
    cq_valid = 1; cq_command = 25'h100;
    #1;
    chk("t3_cqrdy_0", 32'(cq_ready), 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      cq_command = 25'h100 + 25'(i);
      chk($sformatf("t3_lvl_%0d", i), 32'(fifo_level), 32'(i));
      chk($sformatf("t3_cqrdy_%0d", i), 32'(cq_ready), (i == 4) ? 0 : 1);
    end
    tick();
    chk("t3_lvl_stall", 32'(fifo_level), 4);
    chk("t3_cv_stall",  32'(Compute_valid), 0);
    cq_valid = 0;
    tick();
    chk("t3_cv_idle",   32'(Compute_valid), 0);
    Compute_ready = 1;
    tick();
    chk("t3_cv_go",     32'(Compute_valid), 1);
    chk("t3_cmd_go",    32'(Compute_command), 'h100);
    Compute_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_cv_hold%0d", i),  32'(Compute_valid), 1);
      chk($sformatf("t5_cmd_hold%0d", i), 32'(Compute_command), 'h100);
      chk($sformatf("t5_lvl_hold%0d", i), 32'(fifo_level), 4);
    end
    Compute_ready = 1;
    tick();
    chk("t5_cv_acc",  32'(Compute_valid), 0);
    chk("t5_lvl_acc", 32'(fifo_level), 3);
    ls_valid = 1; ls_command = 7'h5A;
    tick();
    chk("t6_lsrdy",   32'(ls_ready), 1);
    tick();
    ls_valid = 0;
    chk("t6_exv",     32'(ExLdSt_valid), 1);
    chk("t6_lvl",     32'(fifo_level), 3);
    tick();
    // reset while holding the macro for load/store
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_r_lvl",   32'(fifo_level), 0);
    chk("t6_r_busy",  32'(busy), 0);
    chk("t6_r_cv",    32'(Compute_valid), 0);
    chk("t6_r_ccmd",  32'(Compute_command), 0);
    chk("t6_r_exv",   32'(ExLdSt_valid), 0);
    chk("t6_r_excmd", 32'(ExLdSt_command), 0);
    chk("t6_r_lsrdy", 32'(ls_ready), 0);
    chk("t6_r_cqrdy", 32'(cq_ready), 1);
    tick();
    chk("t6_r2_exv",  32'(ExLdSt_valid), 0);
    chk("t6_r2_cv",   32'(Compute_valid), 0);
    chk("t6_r2_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
